bus_arbiter: RTL
================

# bus_arbiter

Round-robin multi-host arbiter that shares the single SoC system bus between several masters: core data port, DMA engine and debug module. It sits between the hosts and the `bus` address decoder. It grants one host per cycle, with bounded burst ownership, and forwards that host's request downstream. It routes the one-cycle-latency read response (dpram synchronous read) back to the host that issued the read.

## Interface
- `NrHosts`, 2: number of requesting hosts; must be ≥1; host 0 has first priority after reset.
- `DataWidth`, 32: data width (`XLEN`).
- `AddrWidth`, 32: address width (`XLEN`).
- `MaxBurst`, 4: maximum consecutive granted cycles for one host while others wait; must be ≥1.
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `host_req_i`  in  NrHosts  per-host request; held until granted.
- `host_we_i`  in  NrHosts  per-host write enable.
- `host_addr_i`  in  NrHosts*AddrWidth  host i at `[i*AddrWidth +: AddrWidth]`.
- `host_wdata_i`  in  NrHosts*DataWidth  host i at `[i*DataWidth +: DataWidth]`.
- `host_gnt_o`  out  NrHosts  one-hot (or zero) grant; same-cycle.
- `host_rvalid_o`  out  NrHosts  one-hot read-data-valid, one cycle after a granted read.
- `host_rdata_o`  out  DataWidth  shared read data; meaningful only where `host_rvalid_o` is set.
- `bus_req_o`  out  1  downstream request.
- `bus_we_o`  out  1  downstream write enable.
- `bus_addr_o`  out  AddrWidth  downstream address.
- `bus_wdata_o`  out  DataWidth  downstream write data.
- `bus_rdata_i`  in  DataWidth  downstream read data, valid one cycle after the read request.
- `owner_o`  out  $clog2(NrHosts) (min 1)  index of the current owner; debug only.

## Operation
- State: `IDLE` / `OWNED`.
- Registers:
  - `owner` (host index).
  - `rr_ptr`: next host to be searched first.
  - `burst_cnt`, width $clog2(MaxBurst+1).
  - `rvalid_q`: NrHosts one-hot.
- Round-robin pick: the first host with `host_req_i` set, searching from `start` upward modulo NrHosts. The result is combinational.
- `IDLE`:
  - Pick with `start=rr_ptr`.
  - If a winner exists: grant it this cycle, go to `OWNED`, set `owner`=winner and `burst_cnt`=1.
  - Otherwise stay in `IDLE`.
- `OWNED`, owner's request high and `burst_cnt<MaxBurst`:
  - The owner is granted; `burst_cnt++`.
- `OWNED`, owner's request low or `burst_cnt==MaxBurst`:
  - Re-arbitrate this cycle with `start=owner+1` (mod NrHosts).
  - Winner is granted with `burst_cnt`=1; the old owner can win only if no other host requests.
  - If there is no winner: go to `IDLE` with `rr_ptr=owner+1`.
- Bus when granted host g exists: `bus_req_o`=1; `bus_we_o`, `bus_addr_o`, `bus_wdata_o` are taken from host g.
- Bus when no grant: `bus_req_o`=0, `bus_we_o`=0, addr/wdata all zero.
- Read return:
  - `rvalid_q <= gnt & ~we` for the granted host (zero for writes or no grant).
  - `host_rvalid_o = rvalid_q`; `host_rdata_o = bus_rdata_i` unregistered.
- Writes produce no response.
- Back-to-back reads from different hosts: each rvalid follows its own grant by exactly one cycle, with no overlap hazard.
- `NrHosts==1`: degenerates to a pass-through with `gnt=req`; burst limiting has no effect.

## Timing
- Grant latency is 0 cycles: `host_gnt_o[i]` is asserted combinationally in the cycle `host_req_i[i]` wins.
- A transfer occurs in each cycle where req&gnt; the host updates addr/wdata or drops req in the next cycle.
- Read data latency is 1 cycle after the granted cycle.
- Ownership handover has no bubble: on expiry or release, the new winner is granted in the same cycle.
- Reset (`rst_i` high at a clock edge):
  - `IDLE`, `rr_ptr`=0, `owner`=0, `burst_cnt`=0, `rvalid_q`=0.
  - While `rst_i` is high: `host_gnt_o`=0 and `bus_req_o`=0 regardless of requests; `owner_o`=0.
- Reset mid-operation: ownership is abandoned and an in-flight `rvalid` is dropped (no rvalid in the cycle after reset). Arbitration restarts from host 0.
- Request withdrawn before grant: permitted; no transfer and no state change for that host.

## Test plan
- Reset: `rst_i`=1 for 2 cycles with `host_req_i`=2'b11 -> `host_gnt_o`=0, `bus_req_o`=0, `host_rvalid_o`=0. First cycle after release -> `host_gnt_o`=2'b01.
- Single read: host 0 read of 0x0000_0100, `bus_rdata_i`=0xDEAD_BEEF next cycle -> same cycle: `host_gnt_o`=2'b01, `bus_addr_o`=0x100, `bus_we_o`=0. Next cycle: `host_rvalid_o`=2'b01, `host_rdata_o`=0xDEAD_BEEF.
- Burst fairness: both hosts request continuously, MaxBurst=4 -> grant sequence 0,0,0,0,1,1,1,1,0,… with no idle cycle.
- Early release: host 0 owns and drops req after 2 cycles while host 1 requests -> `host_gnt_o`=2'b10 in the first cycle host 0 is low; `burst_cnt` restarts at 1.
- Sole requester: only host 1 requests for 10 cycles -> `host_gnt_o[1]`=1 every cycle, including across the burst-expiry boundary.
- Reset mid-read: host 1 read granted, `rst_i`=1 the next edge -> `host_rvalid_o`=0 in the following cycle. After release, with both requesting -> host 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one system bus between several hosts, with bounded
// burst ownership and one-cycle read-response routing back to the issuing host.
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int NrHosts   = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int MaxBurst  = 4,
  localparam int IdxW     = (NrHosts > 1) ? $clog2(NrHosts) : 1,
  localparam int CntW     = $clog2(MaxBurst + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrHosts-1:0]             host_req_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [DataWidth-1:0]           host_rdata_o,
  output logic                           bus_req_o,
  output logic                           bus_we_o,
  output logic [AddrWidth-1:0]           bus_addr_o,
  output logic [DataWidth-1:0]           bus_wdata_o,
  input  logic [DataWidth-1:0]           bus_rdata_i,
  output logic [IdxW-1:0]                owner_o
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state;
  logic [IdxW-1:0]     owner;
  logic [IdxW-1:0]     rr_ptr;
  logic [CntW-1:0]     burst_cnt;
  logic [NrHosts-1:0]  rvalid_q;

  logic [IdxW-1:0]     start;
  logic [IdxW-1:0]     scan;
  logic [IdxW-1:0]     win;
  logic                found;
  logic                keep;
  logic [NrHosts-1:0]  gnt;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    if (i == IdxW'(NrHosts - 1)) return '0;
    else                         return i + 1'b1;
  endfunction

  // The owner keeps the bus while it requests and has burst budget left;
  // otherwise the search starts just past it, so it only wins again when alone.
  always_comb begin
    keep  = (state == OWNED) && host_req_i[owner] && (burst_cnt < CntW'(MaxBurst));
    start = (state == OWNED) ? next_idx(owner) : rr_ptr;
    found = 1'b0;
    win   = '0;
    scan  = start;
    for (int k = 0; k < NrHosts; k++) begin
      if (!found && host_req_i[scan]) begin
        found = 1'b1;
        win   = scan;
      end
      scan = next_idx(scan);
    end
  end

  always_comb begin
    gnt = '0;
    if (!rst_i) begin
      if (keep)       gnt[owner] = 1'b1;
      else if (found) gnt[win]   = 1'b1;
    end
  end

  always_comb begin
    bus_req_o   = |gnt;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (gnt[h]) begin
        bus_we_o    = host_we_i[h];
        bus_addr_o  = host_addr_i[h*AddrWidth +: AddrWidth];
        bus_wdata_o = host_wdata_i[h*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rvalid_q  <= '0;
    end else begin
      rvalid_q <= gnt & ~host_we_i;
      if (keep) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else if (found) begin
        state     <= OWNED;
        owner     <= win;
        burst_cnt <= CntW'(1);
      end else if (state == OWNED) begin
        state  <= IDLE;
        rr_ptr <= next_idx(owner);
      end
    end
  end

  assign host_gnt_o    = gnt;
  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = bus_rdata_i;
  assign owner_o       = rst_i ? '0 : owner;

endmodule
